// File: rtl/bru_pkg.sv
// Branch resolve unit shared types.
// Jump kinds, funct3 branch codes and shadow FSM states.
package bru_pkg;

  typedef enum logic [1:0] {
    J_NONE = 2'b00,
    J_JAL  = 2'b01,
    J_JALR = 2'b10
  } jump_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef enum logic {
    SH_IDLE,
    SH_SHADOW
  } shadow_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/bru_lane_eval.sv
// Single-lane branch/jump evaluation.
// Outcome, target, mispredict flag and corrected fetch PC.
module bru_lane_eval
  import bru_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      jump,
  input  logic            branch,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            resolved,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic [XLEN-1:0] correct_pc
);

  logic            is_jal;
  logic            is_jalr;
  logic            is_br;
  logic            cond;
  logic [XLEN-1:0] jalr_sum;

  assign is_jal   = jump == J_JAL;
  assign is_jalr  = jump == J_JALR;
  assign is_br    = branch & ~is_jal & ~is_jalr;
  assign jalr_sum = src_a + imm;
  assign resolved = is_jal | is_jalr | branch;

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = src_a == src_b;
      BR_BNE:  cond = src_a != src_b;
      BR_BLT:  cond = $signed(src_a) < $signed(src_b);
      BR_BGE:  cond = $signed(src_a) >= $signed(src_b);
      BR_BLTU: cond = src_a < src_b;
      BR_BGEU: cond = src_a >= src_b;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = pc + imm;
    unique case (1'b1)
      is_jalr: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      is_jal:  taken = 1'b1;
      is_br:   taken = cond;
      default: ;
    endcase
  end

  assign mispredict = resolved &
    ((taken != pred_taken) |
     (taken & pred_taken & (target != pred_target)));

  assign correct_pc = taken ? target : pc + XLEN'(PC_STEP);

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolution: oldest-mispredict select,
// registered redirect/update outputs, shadow FSM, perf counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int XLEN          = 32,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [LANES-1:0]      valid_i,
  input  logic [LANES*2-1:0]    jump_i,
  input  logic [LANES-1:0]      branch_i,
  input  logic [LANES*3-1:0]    branch_type_i,
  input  logic [LANES*XLEN-1:0] src_a_i,
  input  logic [LANES*XLEN-1:0] src_b_i,
  input  logic [LANES*XLEN-1:0] pc_i,
  input  logic [LANES*XLEN-1:0] imm_i,
  input  logic [LANES-1:0]      pred_taken_i,
  input  logic [LANES*XLEN-1:0] pred_target_i,
  output logic                  redirect_o,
  output logic [XLEN-1:0]       redirect_pc_o,
  output logic [LANES-1:0]      kill_mask_o,
  output logic [LANES-1:0]      upd_valid_o,
  output logic [LANES*XLEN-1:0] upd_pc_o,
  output logic [LANES-1:0]      upd_taken_o,
  output logic [LANES*XLEN-1:0] upd_target_o,
  output logic                  in_shadow_o,
  output logic [CNT_W-1:0]      br_count_o,
  output logic [CNT_W-1:0]      mp_count_o
);

  localparam int SW = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;
  localparam int NW = $clog2(LANES + 1);

  logic [LANES-1:0]      res, tkn, mp, live, kill, upd;
  logic [LANES*XLEN-1:0] tgt, cpc, upd_pc_d, upd_tgt_d;
  logic                  found, go, in_shadow;
  logic [XLEN-1:0]       win_pc;
  logic [NW-1:0]         n_res;
  logic [CNT_W:0]        br_sum;
  logic [CNT_W-1:0]      br_d, mp_d;
  shadow_state_e         st_q, st_d;
  logic [SW-1:0]         cnt_q, cnt_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bru_lane_eval #(.XLEN(XLEN)) u_eval (
      .jump        (jump_i[i*2 +: 2]),
      .branch      (branch_i[i]),
      .br_type     (branch_type_i[i*3 +: 3]),
      .src_a       (src_a_i[i*XLEN +: XLEN]),
      .src_b       (src_b_i[i*XLEN +: XLEN]),
      .pc          (pc_i[i*XLEN +: XLEN]),
      .imm         (imm_i[i*XLEN +: XLEN]),
      .pred_taken  (pred_taken_i[i]),
      .pred_target (pred_target_i[i*XLEN +: XLEN]),
      .resolved    (res[i]),
      .taken       (tkn[i]),
      .target      (tgt[i*XLEN +: XLEN]),
      .mispredict  (mp[i]),
      .correct_pc  (cpc[i*XLEN +: XLEN])
    );
  end

  assign in_shadow   = st_q == SH_SHADOW;
  assign in_shadow_o = in_shadow;
  assign go          = ~stall_i & ~flush_i & ~in_shadow;

  // Oldest mispredicting lane wins; everything younger is squashed.
  always_comb begin
    live      = '0;
    kill      = '0;
    upd       = '0;
    found     = 1'b0;
    win_pc    = '0;
    n_res     = '0;
    upd_pc_d  = '0;
    upd_tgt_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (found) begin
        kill[i] = 1'b1;
      end else begin
        live[i] = valid_i[i] & go;
        if (live[i] & mp[i]) begin
          found  = 1'b1;
          win_pc = cpc[i*XLEN +: XLEN];
        end
      end
      upd[i] = live[i] & res[i];
      if (upd[i]) begin
        n_res = n_res + NW'(1);
        upd_pc_d[i*XLEN +: XLEN]  = pc_i[i*XLEN +: XLEN];
        upd_tgt_d[i*XLEN +: XLEN] = tgt[i*XLEN +: XLEN];
      end
    end
  end

  assign br_sum = {1'b0, br_count_o} + (CNT_W+1)'(n_res);
  assign br_d   = br_sum[CNT_W] ? '1 : br_sum[CNT_W-1:0];
  assign mp_d   = (found && (mp_count_o != '1)) ?
                  mp_count_o + CNT_W'(1) : mp_count_o;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      st_d  = SH_IDLE;
      cnt_d = '0;
    end else if (!stall_i) begin
      unique case (st_q)
        SH_IDLE: begin
          if (found && (SHADOW_CYCLES > 0)) begin
            st_d  = SH_SHADOW;
            cnt_d = SW'(SHADOW_CYCLES);
          end
        end
        SH_SHADOW: begin
          if (cnt_q <= SW'(1)) begin
            st_d  = SH_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= SH_IDLE;
      cnt_q         <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      kill_mask_o   <= '0;
      upd_valid_o   <= '0;
      upd_pc_o      <= '0;
      upd_taken_o   <= '0;
      upd_target_o  <= '0;
      br_count_o    <= '0;
      mp_count_o    <= '0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      redirect_o    <= found;
      redirect_pc_o <= win_pc;
      kill_mask_o   <= kill;
      upd_valid_o   <= upd;
      upd_pc_o      <= upd_pc_d;
      upd_taken_o   <= upd & tkn;
      upd_target_o  <= upd_tgt_d;
      br_count_o    <= br_d;
      mp_count_o    <= mp_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vector bench for branch_resolve_unit.
// LANES=2, SHADOW_CYCLES=2, CNT_W=4.
module tb_branch_resolve_unit;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int SC    = 2;
  localparam int CW    = 4;
  localparam int NV    = 11;

  localparam logic [1:0] JN = 2'b00, JAL = 2'b01, JALR = 2'b10;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100;
  localparam logic [2:0] BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111;

  typedef struct {
    logic        v;
    logic [1:0]  j;
    logic        b;
    logic [2:0]  bt;
    logic [31:0] a, bb, pc, imm;
    logic        pt;
    logic [31:0] ptg;
  } lane_t;

  typedef struct {
    lane_t       l0, l1;
    logic        rd;
    logic [31:0] rpc;
    logic [1:0]  kill, uv, ut;
    logic [31:0] t0, t1;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stall_i, flush_i;
  logic [1:0]  valid_i, branch_i, pred_taken_i;
  logic [3:0]  jump_i;
  logic [5:0]  branch_type_i;
  logic [63:0] src_a_i, src_b_i, pc_i, imm_i, pred_target_i;
  logic        redirect_o, in_shadow_o;
  logic [31:0] redirect_pc_o;
  logic [1:0]  kill_mask_o, upd_valid_o, upd_taken_o;
  logic [63:0] upd_pc_o, upd_target_o;
  logic [CW-1:0] br_count_o, mp_count_o;

  int checks = 0;
  int errors = 0;
  int br_m = 0;
  int mp_m = 0;
  vec_t vt[NV];
  lane_t inv, nop, bmp, bnt;

  branch_resolve_unit #(
    .LANES(LANES), .XLEN(XLEN), .SHADOW_CYCLES(SC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .jump_i(jump_i), .branch_i(branch_i),
    .branch_type_i(branch_type_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .pc_i(pc_i), .imm_i(imm_i), .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .kill_mask_o(kill_mask_o),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
    .upd_taken_o(upd_taken_o), .upd_target_o(upd_target_o),
    .in_shadow_o(in_shadow_o), .br_count_o(br_count_o),
    .mp_count_o(mp_count_o)
  );

  always #5 clk = ~clk;

  function automatic lane_t mk(input logic v, input logic [1:0] j,
      input logic b, input logic [2:0] bt, input logic [31:0] a,
      input logic [31:0] bb, input logic [31:0] pc,
      input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    lane_t l;
    l.v = v; l.j = j; l.b = b; l.bt = bt; l.a = a; l.bb = bb;
    l.pc = pc; l.imm = imm; l.pt = pt; l.ptg = ptg;
    return l;
  endfunction

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic drive(input lane_t l0, input lane_t l1);
    valid_i       = {l1.v, l0.v};
    jump_i        = {l1.j, l0.j};
    branch_i      = {l1.b, l0.b};
    branch_type_i = {l1.bt, l0.bt};
    src_a_i       = {l1.a, l0.a};
    src_b_i       = {l1.bb, l0.bb};
    pc_i          = {l1.pc, l0.pc};
    imm_i         = {l1.imm, l0.imm};
    pred_taken_i  = {l1.pt, l0.pt};
    pred_target_i = {l1.ptg, l0.ptg};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic acc(input int nres, input int nmp);
    br_m = sat(br_m + nres);
    mp_m = sat(mp_m + nmp);
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_br"}, 32'(br_count_o), br_m);
    chk({nm, "_mp"}, 32'(mp_count_o), mp_m);
  endtask

  initial begin
    inv = mk(0, JN, 0, BEQ, 0, 0, 0, 0, 0, 0);
    nop = mk(1, JN, 0, BEQ, 0, 0, 32'h104, 0, 0, 0);
    bmp = mk(1, JN, 1, BEQ, 5, 5, 32'h100, 32'h20, 0, 0);
    bnt = mk(1, JN, 1, BEQ, 1, 2, 32'h40, 32'h8, 0, 0);

    vt[0] = '{bmp, nop, 1, 32'h120, 2'b10, 2'b01, 2'b01, 32'h120, 0};
    vt[1] = '{mk(1, JN, 1, BNE, 1, 2, 32'h200, 32'h40, 0, 0),
              mk(1, JAL, 0, BEQ, 0, 0, 32'h204, 32'h100, 0, 0),
              1, 32'h240, 2'b10, 2'b01, 2'b01, 32'h240, 0};
    vt[2] = '{mk(1, JALR, 0, BEQ, 32'h203, 0, 32'h300, 4, 1, 32'h200),
              nop, 1, 32'h206, 2'b10, 2'b01, 2'b01, 32'h206, 0};
    vt[3] = '{mk(1, JN, 1, BLT, 32'hFFFF_FFFF, 1, 32'h400, 32'h10, 1, 32'h410),
              mk(1, JN, 1, BLTU, 32'hFFFF_FFFF, 1, 32'h404, 8, 0, 0),
              0, 0, 2'b00, 2'b11, 2'b01, 32'h410, 32'h40C};
    vt[4] = '{mk(1, JN, 1, BGE, 32'hFFFF_FFFF, 1, 32'h500, 32'h10, 1, 32'h510),
              nop, 1, 32'h504, 2'b10, 2'b01, 2'b00, 32'h510, 0};
    vt[5] = '{nop,
              mk(1, JN, 1, BGEU, 32'hFFFF_FFFF, 1, 32'h604, 32'hFFFF_FFF8, 0, 0),
              1, 32'h5FC, 2'b00, 2'b10, 2'b10, 0, 32'h5FC};
    vt[6] = '{mk(1, JN, 1, 3'b010, 7, 7, 32'h700, 32'h20, 1, 32'h720),
              nop, 1, 32'h704, 2'b10, 2'b01, 2'b00, 32'h720, 0};
    vt[7] = '{mk(1, JAL, 0, BEQ, 0, 0, 32'h800, 32'h80, 1, 32'h880),
              mk(1, JN, 1, BEQ, 3, 4, 32'h804, 32'h10, 0, 0),
              0, 0, 2'b00, 2'b11, 2'b01, 32'h880, 32'h814};
    vt[8] = '{mk(1, JAL, 1, BNE, 9, 9, 32'h900, 32'h10, 1, 32'h990),
              nop, 1, 32'h910, 2'b10, 2'b01, 2'b01, 32'h910, 0};
    vt[9] = '{mk(0, JN, 1, BEQ, 1, 1, 32'hA00, 32'h10, 0, 0),
              mk(0, JAL, 0, BEQ, 0, 0, 32'hA04, 8, 0, 0),
              0, 0, 2'b00, 2'b00, 2'b00, 0, 0};
    vt[10] = '{mk(1, JN, 1, BNE, 4, 4, 32'hB00, 32'h10, 0, 0),
               mk(1, JN, 1, BEQ, 4, 4, 32'hB04, 32'h30, 0, 0),
               1, 32'hB34, 2'b00, 2'b11, 2'b10, 32'hB10, 32'hB34};

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(inv, inv);
    step(); step();
    chk("rst_redirect", 32'(redirect_o), 0);
    chk("rst_pc", redirect_pc_o, 0);
    chk("rst_kill", 32'(kill_mask_o), 0);
    chk("rst_upd", 32'(upd_valid_o), 0);
    chk("rst_shadow", 32'(in_shadow_o), 0);
    chk_cnt("rst");
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vt[k].l0, vt[k].l1);
      step();
      acc(int'(vt[k].uv[0]) + int'(vt[k].uv[1]), int'(vt[k].rd));
      chk($sformatf("v%0d_redirect", k), 32'(redirect_o), 32'(vt[k].rd));
      if (vt[k].rd)
        chk($sformatf("v%0d_rpc", k), redirect_pc_o, vt[k].rpc);
      chk($sformatf("v%0d_kill", k), 32'(kill_mask_o), 32'(vt[k].kill));
      chk($sformatf("v%0d_uvalid", k), 32'(upd_valid_o), 32'(vt[k].uv));
      chk($sformatf("v%0d_utaken", k), 32'(upd_taken_o), 32'(vt[k].ut));
      if (vt[k].uv[0]) begin
        chk($sformatf("v%0d_upc0", k), upd_pc_o[31:0], vt[k].l0.pc);
        chk($sformatf("v%0d_utgt0", k), upd_target_o[31:0], vt[k].t0);
      end
      if (vt[k].uv[1]) begin
        chk($sformatf("v%0d_upc1", k), upd_pc_o[63:32], vt[k].l1.pc);
        chk($sformatf("v%0d_utgt1", k), upd_target_o[63:32], vt[k].t1);
      end
      chk($sformatf("v%0d_shadow", k), 32'(in_shadow_o), 32'(vt[k].rd));
      chk_cnt($sformatf("v%0d", k));
      drive(inv, inv);
      step();
      chk($sformatf("v%0d_pulse", k), 32'(redirect_o), 0);
      step();
    end

    // Shadow: two bundles squashed, third resolves.
    drive(bmp, nop); step(); acc(1, 1);
    chk("sh_redirect", 32'(redirect_o), 1);
    chk("sh_on", 32'(in_shadow_o), 1);
    step();
    chk("sh_sq1_redirect", 32'(redirect_o), 0);
    chk("sh_sq1_upd", 32'(upd_valid_o), 0);
    chk("sh_sq1_shadow", 32'(in_shadow_o), 1);
    step();
    chk("sh_sq2_redirect", 32'(redirect_o), 0);
    chk("sh_sq2_shadow", 32'(in_shadow_o), 0);
    step(); acc(1, 1);
    chk("sh_third_redirect", 32'(redirect_o), 1);
    chk("sh_third_pc", redirect_pc_o, 32'h120);
    chk_cnt("sh");

    // Stall inside shadow extends it by one cycle.
    stall_i = 1'b1; step();
    chk("st_shadow0", 32'(in_shadow_o), 1);
    chk("st_redirect", 32'(redirect_o), 0);
    stall_i = 1'b0; step();
    chk("st_shadow1", 32'(in_shadow_o), 1);
    step();
    chk("st_shadow2", 32'(in_shadow_o), 0);
    chk("st_sq_redirect", 32'(redirect_o), 0);
    chk_cnt("st");

    // Stall while idle: no pulse, counters frozen.
    stall_i = 1'b1; step();
    chk("sti_redirect", 32'(redirect_o), 0);
    chk("sti_upd", 32'(upd_valid_o), 0);
    chk_cnt("sti");
    stall_i = 1'b0;
    drive(inv, inv); step();

    // Flush mid-shadow ends the window immediately.
    drive(bmp, nop); step(); acc(1, 1);
    chk("fl_redirect", 32'(redirect_o), 1);
    flush_i = 1'b1; step();
    chk("fl_shadow", 32'(in_shadow_o), 0);
    chk("fl_redirect0", 32'(redirect_o), 0);
    chk_cnt("fl");
    flush_i = 1'b0; step(); acc(1, 1);
    chk("fl_after_redirect", 32'(redirect_o), 1);
    drive(inv, inv); step(); step();
    chk("fl_idle", 32'(in_shadow_o), 0);

    // Branch counter saturates at 0xF.
    for (int n = 0; n < 16; n++) begin
      drive(bnt, inv); step(); acc(1, 0);
    end
    chk("sat_br", 32'(br_count_o), 32'hF);
    chk_cnt("sat");

    // Reset while in shadow with a redirect pending.
    drive(bmp, nop); step(); acc(1, 1);
    chk("rs_redirect", 32'(redirect_o), 1);
    chk("rs_shadow", 32'(in_shadow_o), 1);
    rst = 1'b1; step();
    br_m = 0; mp_m = 0;
    chk("rs_redirect0", 32'(redirect_o), 0);
    chk("rs_pc0", redirect_pc_o, 0);
    chk("rs_kill0", 32'(kill_mask_o), 0);
    chk("rs_upd0", 32'(upd_valid_o), 0);
    chk("rs_taken0", 32'(upd_taken_o), 0);
    chk("rs_shadow0", 32'(in_shadow_o), 0);
    chk_cnt("rs");
    rst = 1'b0; step(); acc(1, 1);
    chk("rs_after_redirect", 32'(redirect_o), 1);
    chk_cnt("rs_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
